// File: rtl/panel_key_scheduler.sv
// panel_key_scheduler
// Turns press pulses from a bank of debounced front-panel keys into one ordered
// event stream. Simultaneous presses are served round-robin, keys selected by
// REPEAT_MASK generate auto-repeat events while held, and events are queued in a
// small first-word-fall-through FIFO with a valid/ready handshake.
//
// Ports
//   clk          system clock
//   resetn       asynchronous active-low reset
//   i_state      debounced key levels, 1 = pressed
//   i_ondn       one-cycle press pulses from the debouncers
//   o_evt_valid  FIFO head holds an event
//   i_evt_ready  consumer accepts the head when o_evt_valid & i_evt_ready
//   o_evt_key    key index of the head event
//   o_evt_repeat 1 = auto-repeat event, 0 = fresh press
//   o_drop       one-cycle pulse: a press was lost (key pressed again while unserved)
module panel_key_scheduler #(
    parameter int unsigned N_KEYS        = 8,
    parameter int unsigned HOLD_CYCLES   = 12_500_000,
    parameter int unsigned REPEAT_CYCLES = 2_500_000,
    parameter logic [N_KEYS-1:0] REPEAT_MASK = N_KEYS'(8'h0C),
    parameter int unsigned FIFO_DEPTH    = 4,
    localparam int unsigned KW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [N_KEYS-1:0] i_state,
    input  logic [N_KEYS-1:0] i_ondn,
    output logic              o_evt_valid,
    input  logic              i_evt_ready,
    output logic [KW-1:0]     o_evt_key,
    output logic              o_evt_repeat,
    output logic              o_drop
);

    localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    typedef struct packed {
        logic [KW-1:0] key;
        logic          rpt;
    } evt_t;

    // Registered state
    logic [N_KEYS-1:0] pending_q, pending_d;
    logic              rep_pending_q, rep_pending_d;
    logic [KW-1:0]     rep_key_q, rep_key_d;
    logic [KW-1:0]     rr_ptr_q, rr_ptr_d;
    state_e            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    evt_t              fifo_q [FIFO_DEPTH];
    evt_t              fifo_d [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              valid_q, valid_d;
    logic              drop_q, drop_d;

    // Combinational helpers
    logic              grant_vld;
    logic [KW-1:0]     grant_idx;
    logic              pop;
    logic              can_push;
    logic              push_press;
    logic              push_rep;
    logic              push;
    evt_t              push_evt;
    logic [N_KEYS-1:0] clr;
    logic              retarget;
    logic              held;

    // Round-robin search of registered pending bits starting at rr_ptr
    always_comb begin
        int unsigned idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            idx = (32'(rr_ptr_q) + i) % N_KEYS;
            if (!grant_vld && pending_q[KW'(idx)]) begin
                grant_vld = 1'b1;
                grant_idx = KW'(idx);
            end
        end
    end

    // Push selection, capture, FIFO bookkeeping
    always_comb begin
        pop        = valid_q & i_evt_ready;
        can_push   = (count_q != CW'(FIFO_DEPTH)) | pop;
        // Fresh presses always win; a blocked grant keeps its pending bit and rr_ptr
        push_press = grant_vld & can_push;
        push_rep   = ~grant_vld & rep_pending_q & can_push;
        push       = push_press | push_rep;

        push_evt.key = push_press ? grant_idx : rep_key_q;
        push_evt.rpt = ~push_press;

        clr       = push_press ? (N_KEYS'(1) << grant_idx) : '0;
        pending_d = (pending_q & ~clr) | i_ondn;
        // A second press on a key still waiting for service is lost
        drop_d    = |(i_ondn & pending_q & ~clr);

        rr_ptr_d = rr_ptr_q;
        if (push_press) begin
            rr_ptr_d = (grant_idx == KW'(N_KEYS - 1)) ? '0 : grant_idx + KW'(1);
        end

        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = push_evt;
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        valid_d  = (count_d != '0);
    end

    // Auto-repeat sequencer with one shared timer
    always_comb begin
        state_d       = state_q;
        rep_key_d     = rep_key_q;
        timer_d       = timer_q;
        rep_pending_d = rep_pending_q;
        retarget      = push_press & REPEAT_MASK[grant_idx];
        held          = i_state[rep_key_q];

        if (push_rep) begin
            rep_pending_d = 1'b0;
        end

        if (retarget) begin
            // Last mask-key press wins; an unsent repeat of the old key is abandoned
            state_d       = ST_HOLD;
            rep_key_d     = grant_idx;
            timer_d       = '0;
            rep_pending_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_HOLD: begin
                    if (!held) begin
                        state_d       = ST_IDLE;
                        rep_pending_d = 1'b0;
                    end else if (timer_q == TW'(HOLD_CYCLES - 1)) begin
                        state_d       = ST_REPEAT;
                        timer_d       = '0;
                        rep_pending_d = 1'b1;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_REPEAT: begin
                    if (!held) begin
                        state_d       = ST_IDLE;
                        rep_pending_d = 1'b0;
                    end else if (timer_q == TW'(REPEAT_CYCLES - 1)) begin
                        timer_d       = '0;
                        rep_pending_d = 1'b1;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: begin
                    state_d       = ST_IDLE;
                    rep_pending_d = 1'b0;
                end
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_q     <= '0;
            rep_pending_q <= 1'b0;
            rep_key_q     <= '0;
            rr_ptr_q      <= '0;
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            fifo_q        <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            valid_q       <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            rep_pending_q <= rep_pending_d;
            rep_key_q     <= rep_key_d;
            rr_ptr_q      <= rr_ptr_d;
            state_q       <= state_d;
            timer_q       <= timer_d;
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            valid_q       <= valid_d;
            drop_q        <= drop_d;
        end
    end

    // FIFO head is presented directly (first-word-fall-through)
    assign o_evt_valid  = valid_q;
    assign o_evt_key    = fifo_q[rd_ptr_q].key;
    assign o_evt_repeat = fifo_q[rd_ptr_q].rpt;
    assign o_drop       = drop_q;

endmodule
